fac8_1_twf_feeder: RTL and testbench

- Transmit-side driver for the fac8_1 twiddle multiplier stage of the 16-lane parallel FFT datapath.
- Takes 16-lane butterfly add/sub outputs (R/Q), one block per valid beat.
- Tracks block position inside the FFT frame and registers the data.
- Emits the 3-bit twiddle select cycle-aligned with that data, so the multiplier consumes {select, din_*} on the same edge.

---
 rtl/fac8_1_twf_feeder.sv | 152 +++++++++++++++
 tb/tb_fac8_1_twf_feeder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fac8_1_twf_feeder.sv
`default_nettype none
// ============================================================================
// Module   : fac8_1_twf_feeder
// Purpose  : Registers 16-lane butterfly outputs and emits the fac8_1 twiddle
//            select aligned with them; tracks block position in the FFT frame.
// Options  : FAC8_BITREV_SEL_EN -> bit-reversed twiddle group order.
// Revision : 1.0 - initial release
// ============================================================================
module fac8_1_twf_feeder #(
    parameter int WIDTH      = 11,
    parameter int DEPTH      = 16,
    parameter int FRAME_BLKS = 32,
    parameter int SEL_SHIFT  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    din_valid,
    input  logic                    frame_sync,
    input  logic signed [WIDTH-1:0] din_R_add [DEPTH],
    input  logic signed [WIDTH-1:0] din_R_sub [DEPTH],
    input  logic signed [WIDTH-1:0] din_Q_add [DEPTH],
    input  logic signed [WIDTH-1:0] din_Q_sub [DEPTH],
    output logic                    dout_valid,
    output logic [2:0]              select,
    output logic signed [WIDTH-1:0] dout_R_add [DEPTH],
    output logic signed [WIDTH-1:0] dout_R_sub [DEPTH],
    output logic signed [WIDTH-1:0] dout_Q_add [DEPTH],
    output logic signed [WIDTH-1:0] dout_Q_sub [DEPTH],
    output logic                    frame_start,
    output logic                    frame_end,
    output logic                    sync_err
);

    localparam int              CNT_W    = $clog2(FRAME_BLKS);
    localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(FRAME_BLKS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
    logic [CNT_W-1:0] blk_w;
    logic             accept_w;
    logic             err_w;
    logic [2:0]       group_w;
    logic [2:0]       sel_w;

    logic             dout_valid_q;
    logic [2:0]       select_q;
    logic             frame_start_q;
    logic             frame_end_q;
    logic             sync_err_q;
    logic signed [WIDTH-1:0] r_add_q [DEPTH];
    logic signed [WIDTH-1:0] r_sub_q [DEPTH];
    logic signed [WIDTH-1:0] q_add_q [DEPTH];
    logic signed [WIDTH-1:0] q_sub_q [DEPTH];

    // blk_w is the block index assigned to the current input beat.
    always_comb begin
        state_d   = state_q;
        blk_cnt_d = blk_cnt_q;
        blk_w     = blk_cnt_q;
        accept_w  = 1'b0;
        err_w     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (din_valid && frame_sync) begin
                    accept_w = 1'b1;
                    blk_w    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (din_valid) begin
                    accept_w = 1'b1;
                    if (frame_sync) begin
                        blk_w = '0;
                        err_w = (blk_cnt_q != '0);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Power-of-two frame length: natural counter overflow is the wrap.
        if (accept_w) begin
            blk_cnt_d = blk_w + CNT_W'(1);
        end
    end

    assign group_w = blk_w[SEL_SHIFT +: 3];

`ifdef FAC8_BITREV_SEL_EN
    assign sel_w = {group_w[0], group_w[1], group_w[2]};
`else
    assign sel_w = group_w;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            blk_cnt_q     <= '0;
            dout_valid_q  <= 1'b0;
            select_q      <= '0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            blk_cnt_q     <= blk_cnt_d;
            dout_valid_q  <= accept_w;
            frame_start_q <= accept_w && (blk_w == '0);
            frame_end_q   <= accept_w && (blk_w == LAST_BLK);
            sync_err_q    <= err_w;
            if (accept_w) begin
                select_q <= sel_w;
            end
        end
    end

    // Lane data holds its last value between beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_add_q[i] <= '0;
                r_sub_q[i] <= '0;
                q_add_q[i] <= '0;
                q_sub_q[i] <= '0;
            end
        end else if (accept_w) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_add_q[i] <= din_R_add[i];
                r_sub_q[i] <= din_R_sub[i];
                q_add_q[i] <= din_Q_add[i];
                q_sub_q[i] <= din_Q_sub[i];
            end
        end
    end

    assign dout_valid  = dout_valid_q;
    assign select      = select_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign sync_err    = sync_err_q;
    assign dout_R_add  = r_add_q;
    assign dout_R_sub  = r_sub_q;
    assign dout_Q_add  = q_add_q;
    assign dout_Q_sub  = q_sub_q;

endmodule
`default_nettype wire

// File: tb/tb_fac8_1_twf_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_fac8_1_twf_feeder
// Purpose  : Self-checking bench for fac8_1_twf_feeder against a frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fac8_1_twf_feeder;

    localparam int W  = 11;
    localparam int D  = 16;
    localparam int FB = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic din_valid = 1'b0;
    logic frame_sync = 1'b0;
    logic signed [W-1:0] d_ra [D];
    logic signed [W-1:0] d_rs [D];
    logic signed [W-1:0] d_qa [D];
    logic signed [W-1:0] d_qs [D];
    logic dout_valid, frame_start, frame_end, sync_err;
    logic [2:0] select;
    logic signed [W-1:0] o_ra [D];
    logic signed [W-1:0] o_rs [D];
    logic signed [W-1:0] o_qa [D];
    logic signed [W-1:0] o_qs [D];

    int checks = 0;
    int errors = 0;

    fac8_1_twf_feeder #(.WIDTH(W), .DEPTH(D), .FRAME_BLKS(FB), .SEL_SHIFT(2)) dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .frame_sync(frame_sync),
        .din_R_add(d_ra), .din_R_sub(d_rs), .din_Q_add(d_qa), .din_Q_sub(d_qs),
        .dout_valid(dout_valid), .select(select),
        .dout_R_add(o_ra), .dout_R_sub(o_rs), .dout_Q_add(o_qa), .dout_Q_sub(o_qs),
        .frame_start(frame_start), .frame_end(frame_end), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] sel_of(input int blk);
        int g;
        g = (blk / 4) % 8;
`ifdef FAC8_BITREV_SEL_EN
        case (g)
            0: return 3'd0;  1: return 3'd4;  2: return 3'd2;  3: return 3'd6;
            4: return 3'd1;  5: return 3'd5;  6: return 3'd3;  default: return 3'd7;
        endcase
`else
        return 3'(g);
`endif
    endfunction

    // Frame model: m_pos is the index the next valid beat gets, -1 when unsynced.
    int m_pos;
    logic m_valid, m_start, m_end, m_err;
    logic [2:0] m_sel;
    logic signed [W-1:0] m_ra [D];
    logic signed [W-1:0] m_rs [D];
    logic signed [W-1:0] m_qa [D];
    logic signed [W-1:0] m_qs [D];

    always @(posedge clk or posedge rst) begin
        int blk;
        if (rst) begin
            m_pos = -1; m_valid = 0; m_start = 0; m_end = 0; m_err = 0; m_sel = 0;
            for (int i = 0; i < D; i++) begin
                m_ra[i] = 0; m_rs[i] = 0; m_qa[i] = 0; m_qs[i] = 0;
            end
        end else begin
            m_valid = 0; m_start = 0; m_end = 0; m_err = 0;
            if (din_valid && (frame_sync || m_pos >= 0)) begin
                if (frame_sync) begin
                    m_err = (m_pos > 0);
                    blk = 0;
                end else begin
                    blk = m_pos;
                end
                m_valid = 1;
                m_sel   = sel_of(blk);
                m_start = (blk == 0);
                m_end   = (blk == FB - 1);
                m_pos   = (blk + 1) % FB;
                for (int i = 0; i < D; i++) begin
                    m_ra[i] = d_ra[i]; m_rs[i] = d_rs[i]; m_qa[i] = d_qa[i]; m_qs[i] = d_qs[i];
                end
            end
        end
        #1;
        chk("dout_valid", 32'(dout_valid), 32'(m_valid));
        chk("select", 32'(select), 32'(m_sel));
        chk("frame_start", 32'(frame_start), 32'(m_start));
        chk("frame_end", 32'(frame_end), 32'(m_end));
        chk("sync_err", 32'(sync_err), 32'(m_err));
        for (int i = 0; i < D; i++) begin
            chk($sformatf("R_add[%0d]", i), 32'(o_ra[i]), 32'(m_ra[i]));
            chk($sformatf("R_sub[%0d]", i), 32'(o_rs[i]), 32'(m_rs[i]));
            chk($sformatf("Q_add[%0d]", i), 32'(o_qa[i]), 32'(m_qa[i]));
            chk($sformatf("Q_sub[%0d]", i), 32'(o_qs[i]), 32'(m_qs[i]));
        end
    end

    task automatic rand_data(input bit ramp);
        for (int i = 0; i < D; i++) begin
            d_ra[i] = ramp ? W'(10 + i) : W'($urandom);
            d_rs[i] = W'($urandom);
            d_qa[i] = W'($urandom);
            d_qs[i] = W'($urandom);
        end
    endtask

    // Presents one input cycle, then returns just after its output edge.
    task automatic beat(input logic v, input logic s);
        @(negedge clk);
        din_valid  = v;
        frame_sync = s;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int nvalid;
        rand_data(1'b0);
        #1 rst = 1'b1;
        #20;
        @(negedge clk);
        rst = 1'b0;

        // Unsynced input is ignored.
        for (int k = 0; k < 5; k++) begin
            rand_data(1'b0);
            beat(1'b1, 1'b0);
            chk("idle_valid", 32'(dout_valid), 32'd0);
        end
        chk("idle_select", 32'(select), 32'd0);
        chk("idle_lane", 32'(o_ra[5]), 32'd0);

        // Full contiguous frame with pinned literal expectations.
        for (int b = 0; b < FB; b++) begin
            rand_data(1'b1);
            beat(1'b1, b == 0);
            chk("full_lane3", 32'(o_ra[3]), 32'd13);
            if (b == 0) begin
                chk("full_b0_start", 32'(frame_start), 32'd1);
                chk("full_b0_sel", 32'(select), 32'd0);
            end
            if (b == 4) begin
`ifdef FAC8_BITREV_SEL_EN
                chk("full_b4_sel", 32'(select), 32'd4);
`else
                chk("full_b4_sel", 32'(select), 32'd1);
`endif
            end
            if (b == 12) begin
`ifdef FAC8_BITREV_SEL_EN
                chk("full_b12_sel", 32'(select), 32'd6);
`else
                chk("full_b12_sel", 32'(select), 32'd3);
`endif
            end
            if (b == FB - 1) begin
                chk("full_b31_sel", 32'(select), 32'd7);
                chk("full_b31_end", 32'(frame_end), 32'd1);
            end
        end

        // Second frame wraps without sync.
        for (int b = 0; b < FB; b++) begin
            rand_data(1'b0);
            beat(1'b1, 1'b0);
            if (b == 0) chk("wrap_start", 32'(frame_start), 32'd1);
        end

        // Bubble every other cycle.
        nvalid = 0;
        for (int c = 0; c < 2 * FB; c++) begin
            rand_data(1'b0);
            beat(c % 2 == 0, c == 0);
            if (dout_valid) nvalid++;
        end
        chk("bubble_count", 32'(nvalid), 32'd32);

        // Resync at beat 9.
        for (int b = 0; b <= 9; b++) begin
            rand_data(1'b0);
            beat(1'b1, b == 0 || b == 9);
        end
        chk("resync_err", 32'(sync_err), 32'd1);
        chk("resync_sel", 32'(select), 32'd0);
        chk("resync_start", 32'(frame_start), 32'd1);
        beat(1'b0, 1'b0);
        chk("resync_err_pulse", 32'(sync_err), 32'd0);

        // Asynchronous reset at beat 17 of a fresh frame.
        for (int b = 0; b < 17; b++) begin
            rand_data(1'b0);
            beat(1'b1, b == 0);
        end
        @(negedge clk);
        din_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(dout_valid), 32'd0);
        chk("arst_select", 32'(select), 32'd0);
        chk("arst_lane", 32'(o_qs[7]), 32'd0);
        #2 rst = 1'b0;
        rand_data(1'b0);
        beat(1'b1, 1'b1);
        chk("post_rst_sel", 32'(select), 32'd0);
        chk("post_rst_start", 32'(frame_start), 32'd1);

        // Random traffic, including sync without valid.
        for (int c = 0; c < 700; c++) begin
            rand_data(1'b0);
            beat($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 2);
        end

        beat(1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
